// File: rtl/regfile_access_sequencer_pkg.sv
// Shared types and decode helpers for the register-file access sequencer.
// Register index map: 0..1 sit on the left (PC) bus, 2..13 on the right bus, 14..15 are unused.
package regfile_seq_pkg;

  localparam int NUM_REGS = 14;

  typedef enum logic [1:0] {
    OP_READ   = 2'b00,
    OP_WRITE  = 2'b01,
    OP_COPY   = 2'b10,
    OP_WRITE2 = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    IDLE,
    RD_SET,
    RD_CAP,
    WR,
    ERR
  } state_e;

  localparam logic [3:0] IDX_PC  = 4'd0;
  localparam logic [3:0] IDX_IR  = 4'd1;
  localparam logic [3:0] IDX_WZ  = 4'd2;
  localparam logic [3:0] IDX_SP  = 4'd3;
  localparam logic [3:0] IDX_IY  = 4'd4;
  localparam logic [3:0] IDX_IX  = 4'd5;
  localparam logic [3:0] IDX_HL1 = 4'd6;
  localparam logic [3:0] IDX_HL0 = 4'd7;
  localparam logic [3:0] IDX_DE1 = 4'd8;
  localparam logic [3:0] IDX_DE0 = 4'd9;
  localparam logic [3:0] IDX_BC1 = 4'd10;
  localparam logic [3:0] IDX_BC0 = 4'd11;
  localparam logic [3:0] IDX_AF1 = 4'd12;
  localparam logic [3:0] IDX_AF0 = 4'd13;

  function automatic logic idx_valid(input logic [3:0] idx);
    return idx <= IDX_AF0;
  endfunction

  function automatic logic [NUM_REGS-1:0] idx_to_sel(input logic [3:0] idx);
    logic [NUM_REGS-1:0] sel;
    sel = '0;
    if (idx_valid(idx)) sel[idx] = 1'b1;
    return sel;
  endfunction

  function automatic logic is_left(input logic [3:0] idx);
    return idx <= IDX_IR;
  endfunction

endpackage

// File: rtl/regfile_access_sequencer_if.sv
// Request/response channel between the harness (master) and the sequencer (slave).
interface regfile_access_sequencer_if #(
  parameter int WIDTH = 16
);
  logic             req_valid;
  logic             req_ready;
  logic [1:0]       req_op;
  logic [3:0]       req_src;
  logic [3:0]       req_dst;
  logic [WIDTH-1:0] req_data;
  logic             rsp_valid;
  logic             rsp_err;
  logic [WIDTH-1:0] rsp_data;

  modport master (
    output req_valid, req_op, req_src, req_dst, req_data,
    input  req_ready, rsp_valid, rsp_err, rsp_data
  );

  modport slave (
    input  req_valid, req_op, req_src, req_dst, req_data,
    output req_ready, rsp_valid, rsp_err, rsp_data
  );
endinterface

// File: rtl/regfile_access_sequencer.sv
// Sequences READ/WRITE/COPY/WRITE2 requests onto the register-file slice bus; all outputs registered.
// Latency: WRITE/WRITE2/error 1 edge, READ 2, COPY 3; one request in flight, no response backpressure.
module regfile_access_sequencer
  import regfile_seq_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic                     eclk,
  input  logic                     erst,
  regfile_access_sequencer_if.slave req_if,
  output logic [NUM_REGS-1:0]      regsel,
  output logic                     pc_wr,
  output logic                     reg_wr,
  output logic                     r_p,
  output logic [WIDTH-1:0]         pc_din,
  output logic [WIDTH-1:0]         reg_din,
  input  logic [WIDTH-1:0]         pc_dout,
  input  logic [WIDTH-1:0]         reg_dout
);

  state_e           state_q, state_d;
  op_e              op_q, op_in;
  logic [3:0]       src_q, dst_q;
  logic [WIDTH-1:0] cap_q, cap_d, rd_val;
  logic             accept, bad_in;

  logic                req_ready_q, req_ready_d;
  logic                rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d;
  logic [WIDTH-1:0]    rsp_data_q, rsp_data_d;
  logic [NUM_REGS-1:0] regsel_d;
  logic                pc_wr_d, reg_wr_d, r_p_d;
  logic [WIDTH-1:0]    pc_din_d, reg_din_d;

  assign op_in  = op_e'(req_if.req_op);
  assign accept = req_if.req_valid && req_ready_q;
  // Left slices present their value inverted on pc_dout.
  assign rd_val = is_left(src_q) ? ~pc_dout : reg_dout;

  always_comb begin
    case (op_in)
      OP_READ:  bad_in = !idx_valid(req_if.req_src);
      OP_WRITE: bad_in = !idx_valid(req_if.req_dst);
      default:  bad_in = !idx_valid(req_if.req_src) || !idx_valid(req_if.req_dst);
    endcase
  end

  always_ff @(posedge eclk or posedge erst) begin
    if (erst) begin
      state_q     <= IDLE;
      op_q        <= OP_READ;
      src_q       <= '0;
      dst_q       <= '0;
      cap_q       <= '0;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_data_q  <= '0;
      regsel      <= '0;
      pc_wr       <= 1'b0;
      reg_wr      <= 1'b0;
      r_p         <= 1'b0;
      pc_din      <= '0;
      reg_din     <= '0;
    end else begin
      state_q     <= state_d;
      if (accept) begin
        op_q  <= op_in;
        src_q <= req_if.req_src;
        dst_q <= req_if.req_dst;
      end
      cap_q       <= cap_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_data_q  <= rsp_data_d;
      regsel      <= regsel_d;
      pc_wr       <= pc_wr_d;
      reg_wr      <= reg_wr_d;
      r_p         <= r_p_d;
      pc_din      <= pc_din_d;
      reg_din     <= reg_din_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = bad_in ? ERR :
                                     ((op_in == OP_READ || op_in == OP_COPY) ? RD_SET : WR);
      RD_SET:  state_d = RD_CAP;
      RD_CAP:  state_d = (op_q == OP_COPY) ? WR : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Select is dropped during RD_CAP so a COPY's write select always rises from idle.
  always_comb begin
    regsel_d    = '0;
    pc_wr_d     = 1'b0;
    reg_wr_d    = 1'b0;
    r_p_d       = 1'b0;
    pc_din_d    = '0;
    reg_din_d   = '0;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    rsp_data_d  = '0;
    cap_d       = cap_q;
    req_ready_d = (state_d == IDLE);
    case (state_q)
      IDLE: if (accept && !bad_in) begin
        case (op_in)
          OP_WRITE: begin
            regsel_d = idx_to_sel(req_if.req_dst);
            if (is_left(req_if.req_dst)) begin
              pc_wr_d  = 1'b1;
              pc_din_d = req_if.req_data;
            end else begin
              reg_wr_d  = 1'b1;
              reg_din_d = req_if.req_data;
            end
          end
          OP_WRITE2: begin
            regsel_d = idx_to_sel(req_if.req_src) | idx_to_sel(req_if.req_dst);
            r_p_d    = 1'b1;
            pc_wr_d  = 1'b1;
            pc_din_d = req_if.req_data;
          end
          default: regsel_d = idx_to_sel(req_if.req_src);
        endcase
      end
      RD_CAP: begin
        cap_d = rd_val;
        if (op_q == OP_COPY) begin
          regsel_d = idx_to_sel(dst_q);
          if (is_left(dst_q)) begin
            pc_wr_d  = 1'b1;
            pc_din_d = rd_val;
          end else begin
            reg_wr_d  = 1'b1;
            reg_din_d = rd_val;
          end
        end else begin
          rsp_valid_d = 1'b1;
          rsp_data_d  = rd_val;
        end
      end
      WR: begin
        rsp_valid_d = 1'b1;
        rsp_data_d  = (op_q == OP_COPY) ? cap_q : '0;
      end
      ERR: begin
        rsp_valid_d = 1'b1;
        rsp_err_d   = 1'b1;
      end
      default: ;
    endcase
  end

  assign req_if.req_ready = req_ready_q;
  assign req_if.rsp_valid = rsp_valid_q;
  assign req_if.rsp_err   = rsp_err_q;
  assign req_if.rsp_data  = rsp_data_q;

endmodule

// File: doc/regfile_access_sequencer.md
Name: regfile_access_sequencer

Overview:
Bus master for a row of WIDTH Z80 register-file bit slices in the extracted-netlist simulation model. It accepts read, write, copy and dual-write requests over a valid/ready interface and turns each into correctly timed select, write-strobe, bus-join and data levels for the slices. It captures the slices' registered outputs and returns one response per request. It sits between the test harness or core controller and the slice array.

Parameters:
WIDTH, 16, number of bit slices, which is the data width of each register.

Ports:
eclk  in  1  simulation clock shared with all slices
erst  in  1  reset, asynchronous, active-high
req_valid  in  1  request present
req_ready  out  1  request accepted on an eclk edge when req_valid and req_ready are both high
req_op  in  2  00 READ, 01 WRITE, 10 COPY, 11 WRITE2
req_src  in  4  source register index (READ, COPY); first target (WRITE2)
req_dst  in  4  destination register index (WRITE, COPY); second target (WRITE2)
req_data  in  WIDTH  write data
rsp_valid  out  1  one-cycle response pulse
rsp_err  out  1  qualifies rsp_valid; high means bad index
rsp_data  out  WIDTH  read data (READ, COPY); 0 otherwise
regsel  out  14  one-hot or two-hot register select; bit order PC,IR,WZ,SP,IY,IX,HL1,HL0,DE1,DE0,BC1,BC0,AF1,AF0 for indices 0..13
pc_wr  out  1  left-bus write strobe
reg_wr  out  1  right-bus write strobe
r_p  out  1  join left and right buses
pc_din  out  WIDTH  left-bus write data
reg_din  out  WIDTH  right-bus write data
pc_dout  in  WIDTH  slice left output, registered, inverted polarity
reg_dout  in  WIDTH  slice right output, registered, true polarity

Behaviour:
- Register classes: indices 0 and 1 are the left bus. Indices 2..13 are the right bus. Indices 14 and 15 are invalid.
- All outputs are registered. On erst, every output is 0 and the state is IDLE, asynchronously. A reset mid-operation abandons the request with no response; the write strobes drop immediately.
- Idle bus levels: regsel=0, pc_wr=0, reg_wr=0, r_p=0, pc_din=0, reg_din=0.
- req_ready=1 only in IDLE. There is no response backpressure.
- States: IDLE, RD_SET, RD_CAP, WR, ERR.
- Invalid index in any operand used by the op: IDLE→ERR with no bus activity. In the cycle after ERR, rsp_valid=1, rsp_err=1, rsp_data=0. For READ, req_dst is ignored; for WRITE, req_src is ignored.
- READ, accepted at edge N:
  - Edge N: regsel=onehot(src), r_p=0, no strobes; state RD_SET.
  - Edge N+1: the slices register their outputs; state RD_CAP.
  - Edge N+2: rsp_data captured as ~pc_dout for a left source or reg_dout for a right source. rsp_valid=1 and the bus returns to idle.
  - Latency: rsp_valid high in the cycle after edge N+2.
- WRITE, accepted at edge N:
  - Edge N: regsel=onehot(dst). pc_wr=1 with pc_din=data for a left destination, or reg_wr=1 with reg_din=data for a right destination. r_p=0. State WR.
  - Edge N+1: the slices commit; the bus returns to idle; rsp_valid=1, rsp_data=0.
- COPY: a READ phase on src (RD_SET, RD_CAP), then a WR phase on dst using the captured value in true polarity. rsp_valid comes after the WR edge, at N+3, with rsp_data equal to the copied value. src==dst is legal and leaves the value unchanged.
- WRITE2: regsel=onehot(src)|onehot(dst), r_p=1, pc_wr=1, reg_wr=0, pc_din=data, reg_din=0. One WR cycle, so both registers receive data. src==dst yields a single-bit select.
- A write strobe is never asserted in the same cycle that regsel changes to a new non-idle value from another non-idle value; an idle gap is always present between requests.
- Back-to-back throughput: one request per 2, 3 or 4 edges, since IDLE is re-entered for one cycle.

Decomposition:
- Package regfile_seq_pkg holds:
  - op encodings and state enum
  - register index constants (PC=0 … AF0=13) and NUM_REGS=14
  - function idx_to_sel (4-bit index to 14-bit one-hot, 0 if invalid)
  - function is_left
- No sub-module; the decode functions are sufficient.

Test Plan:
Every scenario below runs on a bench of 16 regfileSlice instances driven by the block.
- WRITE dst=3 (SP) data=16'hBEEF, then READ src=3 -> WRITE rsp at N+1 with err=0; READ rsp_data=16'hBEEF at N+2; regsel during write =14'b00_0000_0000_1000.
- WRITE dst=0 (PC) data=16'h1234, READ src=0 -> pc_wr used, not reg_wr; rsp_data=16'h1234 (inversion undone).
- COPY src=0 (PC=16'h1234) dst=7 (HL0) -> rsp_data=16'h1234 at N+3; a subsequent READ of 7 returns 16'h1234 and PC is unchanged.
- WRITE2 src=1 (IR) dst=13 (AF0) data=16'h00A5 -> r_p=1, pc_wr=1 for one cycle; READs of 1 and 13 both return 16'h00A5.
- READ src=14 -> no regsel activity; rsp_valid with rsp_err=1, rsp_data=0, one cycle after ERR.
- Assert erst in the RD_CAP cycle of a READ -> all outputs 0 immediately, no rsp_valid; after release, req_ready=1 and a new WRITE completes normally.
